// File: rtl/i2c_master.sv
// i2c_master: single-byte register-addressed I2C master (write and read).
// Write: START, addr+W, reg, data, STOP.
// Read:  START, addr+W, reg, repeated START, addr+R, one byte with NACK, STOP.
// Each bit is four quarters of CLK_DIV clocks. SCL is low in q0..q1 and
// released in q2..q3. SDA changes at the start of q0 and is sampled in the
// last cycle of q2.
// Optional macro I2C_MASTER_CLK_STRETCH_EN: the start of q2 waits until the
// synchronised SCL reads high, so a slave can stretch the clock.
// Host handshake: iStart is accepted only in ST_IDLE. The command is latched
// and oBusy rises the next cycle. oBusy falls and oDone pulses for one cycle
// once the STOP has completed. iStart is ignored while busy.
module i2c_master #(
  parameter int CLK_DIV = 250
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iStart,
  input  logic       iRw,
  input  logic [6:0] iSlaveAddr,
  input  logic [7:0] iRegAddr,
  input  logic [7:0] iWData,
  output logic [7:0] oRData,
  output logic       oBusy,
  output logic       oDone,
  output logic       oAckErr,
  output logic [3:0] oDbgState,
  inout  wire        ioSCL,
  inout  wire        ioSDA
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_START, ST_TX_BYTE, ST_RX_ACK, ST_RESTART,
    ST_RX_BYTE, ST_TX_NACK, ST_STOP, ST_DONE
  } state_e;

  localparam logic [15:0] LAST = 16'(CLK_DIV - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  q_q, q_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_q, rx_d;
  logic        ack_q, ack_d;
  logic        rw_q, rw_d;
  logic [6:0]  addr_q, addr_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        ack_err_q, ack_err_d;
  logic        sda_s1_q, sda_s2_q;
  logic        scl_low, sda_low;
  logic        hold, quarter_end, sample, bit_end;

  // The line read back from SDA passes through a 2-flop synchroniser.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
    end else begin
      sda_s1_q <= ioSDA;
      sda_s2_q <= sda_s1_q;
    end
  end

`ifdef I2C_MASTER_CLK_STRETCH_EN
  logic scl_s1_q, scl_s2_q;

  // The line read back from SCL is synchronised the same way. It is used
  // only to detect a slave holding the clock low.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
    end else begin
      scl_s1_q <= ioSCL;
      scl_s2_q <= scl_s1_q;
    end
  end

  assign hold = (state_q != ST_IDLE) && (state_q != ST_DONE) &&
                (q_q == 2'd2) && (cnt_q == 16'd0) && !scl_s2_q;
`else
  assign hold = 1'b0;
`endif

  assign quarter_end = (cnt_q == LAST) && !hold;
  assign sample      = quarter_end && (q_q == 2'd2);
  assign bit_end     = quarter_end && (q_q == 2'd3);

  // State register, bit timing and the captured command.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      q_q       <= '0;
      bit_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      rx_q      <= '0;
      ack_q     <= 1'b0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      reg_q     <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      bit_q     <= bit_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      rx_q      <= rx_d;
      ack_q     <= ack_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      reg_q     <= reg_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      ack_err_q <= ack_err_d;
    end
  end

  // Next state, quarter/phase counting, the byte sequencer and the line enables.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    bit_d     = bit_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    rx_d      = rx_q;
    ack_d     = ack_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    reg_d     = reg_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    ack_err_d = ack_err_q;
    scl_low   = 1'b0;
    sda_low   = 1'b0;

    if (state_q == ST_IDLE || state_q == ST_DONE) begin
      cnt_d = '0;
      q_d   = '0;
    end else if (!hold) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        q_d   = q_q + 2'd1;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          rw_d      = iRw;
          addr_d    = iSlaveAddr;
          reg_d     = iRegAddr;
          wdata_d   = iWData;
          ack_err_d = 1'b0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        scl_low = (q_q == 2'd3);
        sda_low = (q_q != 2'd0);
        if (bit_end) begin
          state_d = ST_TX_BYTE;
          shift_d = {addr_q, 1'b0};
          bit_d   = 3'd7;
          idx_d   = 2'd0;
        end
      end
      ST_TX_BYTE: begin
        scl_low = !q_q[1];
        sda_low = !shift_q[7];
        if (bit_end) begin
          if (bit_q == 3'd0) begin
            state_d = ST_RX_ACK;
          end else begin
            bit_d   = bit_q - 3'd1;
            shift_d = {shift_q[6:0], 1'b0};
          end
        end
      end
      ST_RX_ACK: begin
        scl_low = !q_q[1];
        if (sample) ack_d = sda_s2_q;
        if (bit_end) begin
          bit_d = 3'd7;
          if (ack_q) begin
            ack_err_d = 1'b1;
            state_d   = ST_STOP;
          end else begin
            unique case (idx_q)
              2'd0: begin
                state_d = ST_TX_BYTE;
                shift_d = reg_q;
                idx_d   = 2'd1;
              end
              2'd1: begin
                idx_d = 2'd2;
                if (rw_q) begin
                  state_d = ST_RESTART;
                end else begin
                  state_d = ST_TX_BYTE;
                  shift_d = wdata_q;
                end
              end
              default: state_d = rw_q ? ST_RX_BYTE : ST_STOP;
            endcase
          end
        end
      end
      ST_RESTART: begin
        scl_low = !q_q[1];
        sda_low = (q_q == 2'd3);
        if (bit_end) begin
          state_d = ST_TX_BYTE;
          shift_d = {addr_q, 1'b1};
          bit_d   = 3'd7;
        end
      end
      ST_RX_BYTE: begin
        scl_low = !q_q[1];
        if (sample) rx_d = {rx_q[6:0], sda_s2_q};
        if (bit_end) begin
          if (bit_q == 3'd0) begin
            rdata_d = rx_q;
            state_d = ST_TX_NACK;
          end else begin
            bit_d = bit_q - 3'd1;
          end
        end
      end
      ST_TX_NACK: begin
        scl_low = !q_q[1];
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        scl_low = !q_q[1];
        sda_low = (q_q != 2'd3);
        if (bit_end) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Open drain: the block only ever pulls a line low or releases it.
  assign ioSCL = scl_low ? 1'b0 : 1'bz;
  assign ioSDA = sda_low ? 1'b0 : 1'bz;

  assign oRData    = rdata_q;
  assign oBusy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign oDone     = (state_q == ST_DONE);
  assign oAckErr   = ack_err_q;
  assign oDbgState = state_q;

endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: exercises i2c_master against a behavioural I2C register
// slave (four registers at address 0x54). Expectations come from a
// transaction-level model: register contents, expected read data, the NACK
// flag and nominal latency from bit counts.
module tb_i2c_master;

  localparam int          K   = 4;
  localparam logic [6:0]  SLV = 7'h54;
`ifdef I2C_MASTER_CLK_STRETCH_EN
  localparam int          LAT_TOL = 160;
`else
  localparam int          LAT_TOL = 3;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start_i = 1'b0;
  logic       rw_i = 1'b0;
  logic [6:0] addr_i = '0;
  logic [7:0] reg_i = '0;
  logic [7:0] wdata_i = '0;
  logic [7:0] rdata_o;
  logic       busy_o, done_o, ack_err_o;
  logic [3:0] dbg_state;
  wire        scl, sda;

  pullup (scl);
  pullup (sda);

  i2c_master #(.CLK_DIV(K)) dut (
    .iClk(clk), .iRst_n(rst_n), .iStart(start_i), .iRw(rw_i),
    .iSlaveAddr(addr_i), .iRegAddr(reg_i), .iWData(wdata_i),
    .oRData(rdata_o), .oBusy(busy_o), .oDone(done_o), .oAckErr(ack_err_o),
    .oDbgState(dbg_state), .ioSCL(scl), .ioSDA(sda)
  );

  // ---------------- behavioural slave ----------------
  logic       sl_drive_low = 1'b0;
  logic       tb_scl_low = 1'b0;
  logic       p_scl = 1'b1, p_sda = 1'b1;
  int         sl_bitcnt = 0, sl_byte_no = 0;
  int         sl_starts = 0, sl_stops = 0, sl_nacks = 0;
  logic       sl_active = 1'b0, sl_rw = 1'b0, sl_tx = 1'b0;
  logic [7:0] sl_sh = '0, sl_ptr = '0, sl_tx_byte = '0;
  logic [7:0] sl_regs [4] = '{default: 8'h00};
  logic       stretch_req = 1'b0;
  int         stretch_cnt = 0;

  assign sda = sl_drive_low ? 1'b0 : 1'bz;
  assign scl = tb_scl_low   ? 1'b0 : 1'bz;

  always @(negedge clk) begin
    p_scl <= scl;
    p_sda <= sda;
    if (stretch_cnt > 0) begin
      stretch_cnt <= stretch_cnt - 1;
      if (stretch_cnt == 1) tb_scl_low <= 1'b0;
    end
    if (p_scl && scl && p_sda && !sda) begin
      sl_starts    <= sl_starts + 1;
      sl_bitcnt    <= 0;
      sl_byte_no   <= 0;
      sl_tx        <= 1'b0;
      sl_drive_low <= 1'b0;
    end else if (p_scl && scl && !p_sda && sda) begin
      sl_stops     <= sl_stops + 1;
      sl_active    <= 1'b0;
      sl_tx        <= 1'b0;
      sl_bitcnt    <= 0;
      sl_drive_low <= 1'b0;
    end else if (!p_scl && scl) begin
      if (sl_bitcnt < 8) begin
        sl_sh     <= {sl_sh[6:0], sda};
        sl_bitcnt <= sl_bitcnt + 1;
      end else if (sl_bitcnt == 8) begin
        if (sl_tx && sda) sl_nacks <= sl_nacks + 1;
        sl_bitcnt <= 9;
      end
    end else if (p_scl && !scl) begin
      if (stretch_req && stretch_cnt == 0 && !tb_scl_low &&
          sl_byte_no == 2 && sl_bitcnt == 3) begin
        tb_scl_low  <= 1'b1;
        stretch_cnt <= 500;
      end
      if (sl_bitcnt == 8 && !sl_tx) begin
        case (sl_byte_no)
          0: begin
            if (sl_sh[7:1] == SLV) begin
              sl_active    <= 1'b1;
              sl_rw        <= sl_sh[0];
              sl_drive_low <= 1'b1;
            end else begin
              sl_active <= 1'b0;
            end
          end
          1: if (sl_active) begin
            sl_ptr       <= sl_sh;
            sl_drive_low <= 1'b1;
          end
          2: if (sl_active && !sl_rw) begin
            sl_regs[sl_ptr[1:0]] <= sl_sh;
            sl_drive_low         <= 1'b1;
          end
          default: ;
        endcase
      end else if (sl_bitcnt == 8 && sl_tx) begin
        sl_drive_low <= 1'b0;
      end else if (sl_bitcnt == 9) begin
        sl_bitcnt  <= 0;
        sl_byte_no <= sl_byte_no + 1;
        if (sl_active && sl_rw && !sl_tx && sl_byte_no == 0) begin
          sl_tx        <= 1'b1;
          sl_tx_byte   <= sl_regs[sl_ptr[1:0]];
          sl_drive_low <= !sl_regs[sl_ptr[1:0]][7];
        end else begin
          sl_tx        <= 1'b0;
          sl_drive_low <= 1'b0;
        end
      end else if (sl_tx && sl_bitcnt >= 1 && sl_bitcnt <= 7) begin
        sl_drive_low <= !sl_tx_byte[7 - sl_bitcnt];
      end
    end
  end

  // ---------------- scoreboard / model ----------------
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_q [$];
  logic [7:0] exp_regs [4] = '{default: 8'h00};
  logic [7:0] exp_rdata = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_txn(input logic rw, input logic [6:0] addr, input logic [7:0] ra,
                        input logic [7:0] wd, input bit disturb, output int lat);
    int extra;
    @(negedge clk);
    rw_i = rw; addr_i = addr; reg_i = ra; wdata_i = wd; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    lat = 0;
    chk("busy_rise", busy_o, 1'b1);
    while (!done_o && lat < 4000) begin
      if (disturb) begin
        start_i = (lat >= 40 && lat < 48);
        wdata_i = 8'h3C; rw_i = 1'b0; addr_i = SLV;
      end
      @(posedge clk); #1;
      lat++;
    end
    start_i = 1'b0;
    chk("done_timeout", (lat < 4000), 1'b1);
    chk("busy_at_done", busy_o, 1'b0);
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done_o) extra++;
    end
    chk("single_done", extra, 0);
  endtask

  task automatic run_txn(input logic rw, input logic [6:0] addr, input logic [7:0] ra,
                         input logic [7:0] wd, input bit disturb, output int lat);
    bit ok;
    int nom, st0, sp0, nk0;
    logic [7:0] e;
    ok  = (addr == SLV);
    nom = !ok ? 44 * K : (rw ? 156 * K : 116 * K);
    if (ok && rw) exp_q.push_back(exp_regs[ra[1:0]]);
    if (ok && !rw) exp_regs[ra[1:0]] = wd;
    st0 = sl_starts; sp0 = sl_stops; nk0 = sl_nacks;
    do_txn(rw, addr, ra, wd, disturb, lat);
    chk($sformatf("latency(got %0d nominal %0d)", lat, nom),
        (lat >= nom - LAT_TOL && lat <= nom + LAT_TOL), 1'b1);
    chk("ack_err", ack_err_o, !ok);
    chk("starts", sl_starts - st0, (ok && rw) ? 2 : 1);
    chk("stops", sl_stops - sp0, 1);
    chk("master_nack", sl_nacks - nk0, (ok && rw) ? 1 : 0);
    if (ok && rw) begin
      e = exp_q.pop_front();
      exp_rdata = e;
    end
    chk("rdata", rdata_o, exp_rdata);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lat, lat_base;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", rdata_o, 8'h00);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_ackerr", ack_err_o, 1'b0);
    chk("rst_scl", scl, 1'b1);
    chk("rst_sda", sda, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // directed: write, read back, address NACK, start while busy
    run_txn(1'b0, SLV, 8'h02, 8'hA5, 1'b0, lat);
    run_txn(1'b1, SLV, 8'h02, 8'h00, 1'b0, lat);
    run_txn(1'b0, 7'h55, 8'h01, 8'h77, 1'b0, lat);
    run_txn(1'b0, SLV, 8'h02, 8'hA5, 1'b1, lat);

    // reset in the middle of the register byte
    @(negedge clk);
    rw_i = 1'b0; addr_i = SLV; reg_i = 8'h03; wdata_i = 8'h77; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (13 * 4 * K) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("midrst_scl", scl, 1'b1);
    chk("midrst_sda", sda, 1'b1);
    chk("midrst_busy", busy_o, 1'b0);
    chk("midrst_rdata", rdata_o, 8'h00);
    exp_rdata = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    run_txn(1'b0, SLV, 8'h03, 8'h11, 1'b0, lat);
    chk("reg3_after_reset", sl_regs[3], 8'h11);

    // randomized traffic
    for (int i = 0; i < 16; i++) begin
      logic       r;
      logic [6:0] a;
      r = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : SLV;
      run_txn(r, a, 8'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 1'b0, lat);
    end

`ifdef I2C_MASTER_CLK_STRETCH_EN
    run_txn(1'b0, SLV, 8'h01, 8'h5A, 1'b0, lat_base);
    stretch_req = 1'b1;
    run_txn(1'b0, SLV, 8'h01, 8'hC3, 1'b0, lat);
    stretch_req = 1'b0;
    chk($sformatf("stretch_delay(%0d)", lat - lat_base),
        (lat - lat_base >= 480 && lat - lat_base <= 505), 1'b1);
`else
    lat_base = 0;
`endif

    for (int r = 0; r < 4; r++) chk($sformatf("slave_reg%0d", r), sl_regs[r], exp_regs[r]);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_master.md
Name: i2c_master

Overview:
Single-byte I2C master that issues register-addressed write and read transactions on the open-drain ioSCL/ioSDA bus toward I2C_Slave-class devices. This is the upstream stage that drives I2C_Slave.
- Write transaction: START, addr+W, reg, data, STOP.
- Read transaction: START, addr+W, reg, repeated START, addr+R, one data byte with master NACK, STOP.
- Host side is a start/busy/done command interface used by the board-level top (Basys3).

Parameters:
CLK_DIV, 250, system clocks per SCL quarter-period (100 MHz / (4*250) = 100 kHz SCL); legal range 4..65535.

Ports:
iClk  input  1  system clock
iRst_n  input  1  asynchronous active-low reset
iStart  input  1  command strobe; sampled only in ST_IDLE
iRw  input  1  0 = write, 1 = read; captured with iStart
iSlaveAddr  input  7  7-bit target address; captured with iStart
iRegAddr  input  8  register pointer byte; captured with iStart
iWData  input  8  write data byte; captured with iStart
oRData  output  8  read data byte; valid when oDone=1 and iRw was 1
oBusy  output  1  transaction in progress
oDone  output  1  one-cycle completion pulse
oAckErr  output  1  a NACK was received during the last transaction; held until the next accepted iStart
ioSCL  inout  1  open-drain SCL: drives 0 or z
ioSDA  inout  1  open-drain SDA: drives 0 or z

Behaviour:
- Clock and reset: one clock, iClk. Reset iRst_n is asynchronous and active-low.
- Reset values: oRData=0, oBusy=0, oDone=0, oAckErr=0, both line enables off (lines z). The state machine enters ST_IDLE. An asserted reset mid-transfer releases both lines immediately.
- Inputs: ioSCL and ioSDA are read back through 2-flop synchronisers.
- Bit timing: a quarter counter counts 0..CLK_DIV-1; the phase counter q advances 0..3 on each wrap. One bit lasts 4*CLK_DIV cycles.
  - q0: SCL low; SDA updated at the start of q0.
  - q1: SCL low.
  - q2, q3: SCL released.
  - SDA is sampled at the last cycle of q2.
- Handshake:
  - iStart=1 in ST_IDLE latches all command inputs, clears oAckErr, and sets oBusy the next cycle.
  - iStart while busy is ignored.
  - oDone pulses exactly one cycle after the STOP completes; oBusy drops in the same cycle.
- State machine:
  - ST_IDLE: both lines released.
  - ST_START: SDA pulled low at q1 while SCL is high; SCL pulled low from q3. Duration 4 quarters.
  - ST_TX_BYTE: shifts out 8 bits MSB first. A 0 bit pulls SDA low; a 1 bit releases it.
  - ST_RX_ACK: SDA released; sampled bit stored in ack.
    - ack=1 (NACK): set oAckErr, go to ST_STOP.
    - ack=0: go to the next byte per the byte sequencer.
  - ST_RESTART (read path only, after the reg byte ACK):
    - q0–q1: SCL low, SDA released.
    - q2: SCL released.
    - q3: SDA pulled low while SCL is high.
    - Then ST_TX_BYTE with {addr,1}.
  - ST_RX_BYTE: SDA released; 8 bits sampled MSB first into a shift register, copied to oRData after bit 0.
  - ST_TX_NACK: SDA released for one bit period; always NACK, since reads are single-byte.
  - ST_STOP:
    - q0–q1: SDA low, SCL low.
    - q2: SCL released.
    - q3: SDA released while SCL is high.
    - Then ST_DONE.
  - ST_DONE: oDone=1 for one cycle, then ST_IDLE.
- Byte sequencer: 2-bit index.
  - Write: {addr,0} -> reg -> data -> STOP.
  - Read: {addr,0} -> reg -> RESTART -> {addr,1} -> RX_BYTE -> TX_NACK -> STOP.
- Nominal latency from iStart acceptance to oDone:
  - Write: 116*CLK_DIV cycles (start + 27 bits + stop quarters).
  - Read: 156*CLK_DIV cycles.
  - Tolerance ±3 cycles; a NACK shortens the transaction.
- NACK on the addr byte: no further bytes are sent and the STOP is issued. oRData is unchanged on a failed read.
- Line ownership: the block never drives 1. SDA changes only while SCL is low, except the START, RESTART and STOP edges.

Optional Feature:
Macro I2C_MASTER_CLK_STRETCH_EN.
- When defined: on entering q2 the quarter counter holds at 0 until the synchronised SCL reads 1, so a slave holding SCL low extends the bit. q2 sampling then starts from the observed rise.
- When undefined: SCL is assumed to follow the master. Timing is fixed at 4*CLK_DIV cycles per bit and synchronised SCL is ignored.

Test Plan:
- Write: CLK_DIV=4, slave 0x54; write reg 0x02 data 0xA5 -> I2C_Slave oReg2=0xA5, oAckErr=0, oDone after ~464 cycles.
- Read: read back reg 0x02 from 0x54 -> repeated START observed, oRData=0xA5, oAckErr=0, final bit NACK, STOP seen.
- Address NACK: write to address 0x55 -> oAckErr=1, STOP follows the 9th bit, oDone pulses, slave oReg0..3 unchanged.
- Command while busy: iStart held/pulsed during a busy write with different data 0x3C -> ignored; only 0xA5 written, single oDone.
- Reset recovery: iRst_n low mid reg byte -> ioSCL=ioSDA=1 (pull-up) within 1 cycle, oBusy=0; the next write of 0x11 to reg 3 succeeds and oReg3=0x11.
- Clock stretching: with I2C_MASTER_CLK_STRETCH_EN, the bench holds SCL low 500 cycles during data bit 3 -> write completes correctly and oDone is delayed by ~500 cycles versus nominal.
